imem_loader: RTL and testbench

Program loader and the write side of the byte-addressed, big-endian instruction memory. It accepts a byte stream over a valid/ready handshake and emits sequential byte writes starting at address 0. It zero-pads a final partial instruction word and holds the CPU until a complete image is in memory. It sits between the host/boot link and the instruction memory write port, ahead of instruction fetch.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the boot link plus the instruction-memory write port
// and status outputs of the loader.
interface imem_loader_if #(
   parameter int ADDR_W = 32
) ();
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_last;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W-1:0] word_count;

   modport master (
      output start, in_valid, in_data, in_last,
      input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
   );

   modport slave (
      input  start, in_valid, in_data, in_last,
      output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
   );
endinterface

// File: rtl/imem_loader.sv
// Program loader: turns a byte stream into sequential big-endian instruction-memory
// writes from address 0, zero-pads the last word and holds the CPU until done.
module imem_loader #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, PAD, DONE, ERR} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic [ADDR_W-1:0] word_count_q, word_count_d;

   // in_ready depends on the state only, never on in_valid
   assign bus.in_ready   = (state_q == LOAD);
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.cpu_hold   = cpu_hold_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;
   assign bus.word_count = word_count_q;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      cpu_hold_d   = 1'b1;
      word_count_d = '0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               ptr_d   = '0;
            end
         end
         LOAD: begin
            if (bus.in_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               wr_data_d = bus.in_data;
               ptr_d     = ptr_q + ONE;
               if (bus.in_last) begin
                  state_d = (ptr_q[1:0] == 2'd3) ? DONE : PAD;
               end else if (ptr_q == LAST_ADDR) begin
                  // Overflowing byte is still written; error shows with its write
                  state_d = ERR;
                  error_d = 1'b1;
               end
            end
         end
         PAD: begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = 8'h00;
            ptr_d     = ptr_q + ONE;
            if (ptr_q[1:0] == 2'd3) state_d = DONE;
         end
         DONE: begin
            // done lags entry by a cycle so the last write is captured first
            if (bus.start) begin
               state_d = LOAD;
               ptr_d   = '0;
            end else begin
               done_d       = 1'b1;
               cpu_hold_d   = 1'b0;
               word_count_d = ptr_q >> 2;
            end
         end
         ERR: begin
            if (bus.start) begin
               state_d = LOAD;
               ptr_d   = '0;
            end else begin
               error_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         cpu_hold_q   <= 1'b1;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         done_q       <= done_d;
         error_q      <= error_d;
         cpu_hold_q   <= cpu_hold_d;
         word_count_q <= word_count_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random byte images compared against an
// image model (data followed by zero padding to a word boundary).
module tb_imem_loader;

   localparam int MEMB = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   imem_loader_if #(.ADDR_W(32)) bus ();

   imem_loader #(.MEM_BYTES(MEMB), .ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned a;
      logic [7:0]  d;
   } wr_t;

   wr_t        wq[$];
   logic [7:0] mem [0:MEMB-1];
   int         accepts = 0;

   // Instruction memory stand-in and write/accept log
   always @(posedge clk) begin
      if (bus.wr_en === 1'b1) begin
         wq.push_back('{bus.wr_addr, bus.wr_data});
         if (bus.wr_addr < MEMB) mem[bus.wr_addr[3:0]] <= bus.wr_data;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) accepts <= accepts + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic push(input logic [7:0] d, input logic last, output logic ok);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (bus.in_ready === 1'b1) begin
            @(negedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic pulse_start(input logic valid_too, input logic [7:0] d);
      bus.start    = 1'b1;
      bus.in_valid = valid_too;
      bus.in_data  = d;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input int pad);
      int cnt = 0;
      for (int t = 0; t < 20; t++) begin
         if (bus.done === 1'b1) break;
         @(negedge clk);
         cnt++;
      end
      chk("done_latency", cnt, pad + 1);
   endtask

   // Expected writes: image bytes then zeros up to the next multiple of 4
   task automatic check_writes(input int w0, input int acc0, input logic [7:0] img[$]);
      int n = img.size();
      int padded = ((n + 3) / 4) * 4;
      int got = wq.size() - w0;
      chk("write_count", got, padded);
      chk("accept_count", accepts - acc0, n);
      for (int i = 0; i < padded && i < got; i++) begin
         chk("wr_addr", wq[w0+i].a, i);
         chk("wr_data", wq[w0+i].d, (i < n) ? img[i] : 8'h00);
      end
   endtask

   // Full load: start (optionally with a byte already offered), then bytes with gaps
   task automatic do_load(input logic [7:0] img[$], input int gap, input logic valid_at_start);
      int   w0 = wq.size();
      int   acc0 = accepts;
      int   n = img.size();
      logic ok;
      pulse_start(valid_at_start, img[0]);
      for (int i = 0; i < n; i++) begin
         int g = (gap < 0) ? $urandom_range(0, 3) : gap;
         if (i > 0) repeat (g) @(negedge clk);
         push(img[i], (i == n - 1), ok);
         chk("accepted", ok, 1'b1);
      end
      chk("hold_before_done", bus.cpu_hold, 1'b1);
      wait_done(((n + 3) / 4) * 4 - n);
      chk("done", bus.done, 1'b1);
      chk("cpu_hold_released", bus.cpu_hold, 1'b0);
      chk("word_count", bus.word_count, (n + 3) / 4);
      chk("in_ready_done", bus.in_ready, 1'b0);
      check_writes(w0, acc0, img);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
      chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
      chk({tag, "_error"}, bus.error, 1'b0);
      chk({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
      chk({tag, "_wr_data"}, bus.wr_data, 8'd0);
      chk({tag, "_word_count"}, bus.word_count, 32'd0);
      chk({tag, "_cpu_hold"}, bus.cpu_hold, 1'b1);
   endtask

   initial begin
      logic [7:0] img[$];
      logic [7:0] prog[$];
      logic       ok;
      int         w0, acc0;

      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("idle");

      // Aligned two-instruction program
      prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
      do_load(prog, 0, 1'b0);
      chk("fetch_0", {mem[0], mem[1], mem[2], mem[3]}, 32'h20080005);
      chk("fetch_4", {mem[4], mem[5], mem[6], mem[7]}, 32'h20090007);

      // Partial final word, start coinciding with an offered byte
      img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      do_load(img, 0, 1'b1);
      chk("fetch_4_pad", {mem[4], mem[5], mem[6], mem[7]}, 32'h55660000);

      // Gapped source
      do_load(prog, 3, 1'b0);
      chk("gap_fetch_4", {mem[4], mem[5], mem[6], mem[7]}, 32'h20090007);

      // Random images and gaps
      for (int r = 0; r < 6; r++) begin
         int n = $urandom_range(1, MEMB);
         img.delete();
         for (int i = 0; i < n; i++) img.push_back(8'($urandom));
         do_load(img, -1, 1'($urandom_range(0, 1)));
      end

      // Overflow: 16 bytes with no last, then a 17th that must not be taken
      w0   = wq.size();
      acc0 = accepts;
      img.delete();
      for (int i = 0; i < MEMB; i++) img.push_back(8'($urandom));
      pulse_start(1'b0, 8'h00);
      for (int i = 0; i < MEMB; i++) begin
         push(img[i], 1'b0, ok);
         chk("ovf_accepted", ok, 1'b1);
      end
      chk("ovf_error", bus.error, 1'b1);
      chk("ovf_in_ready", bus.in_ready, 1'b0);
      chk("ovf_cpu_hold", bus.cpu_hold, 1'b1);
      chk("ovf_done", bus.done, 1'b0);
      push(8'hEE, 1'b0, ok);
      chk("ovf_17th_refused", ok, 1'b0);
      chk("ovf_writes", wq.size() - w0, MEMB);
      chk("ovf_accepts", accepts - acc0, MEMB);
      for (int i = 0; i < MEMB && w0 + i < wq.size(); i++) begin
         chk("ovf_addr", wq[w0+i].a, i);
         chk("ovf_data", wq[w0+i].d, img[i]);
      end
      pulse_start(1'b0, 8'h00);
      chk("err_cleared", bus.error, 1'b0);
      chk("err_restart_ready", bus.in_ready, 1'b1);

      // Reset after three accepts
      for (int i = 0; i < 3; i++) begin
         push(8'(8'hA0 + i), 1'b0, ok);
         chk("rst_pre_accept", ok, 1'b1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("midload_reset");
      rst_n = 1'b1;
      @(negedge clk);
      img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_load(img, 0, 1'b0);
      chk("reload_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'hDEADBEEF);

      // Start during LOAD is ignored; start in DONE restarts at address 0
      w0   = wq.size();
      acc0 = accepts;
      img  = '{8'h01, 8'h02, 8'h03, 8'h04};
      pulse_start(1'b0, 8'h00);
      push(img[0], 1'b0, ok);
      push(img[1], 1'b0, ok);
      pulse_start(1'b0, 8'h00);
      push(img[2], 1'b0, ok);
      push(img[3], 1'b1, ok);
      wait_done(0);
      chk("restart_wc", bus.word_count, 32'd1);
      check_writes(w0, acc0, img);
      pulse_start(1'b0, 8'h00);
      chk("restart_done_clr", bus.done, 1'b0);
      chk("restart_hold", bus.cpu_hold, 1'b1);
      chk("restart_wc_clr", bus.word_count, 32'd0);
      w0   = wq.size();
      acc0 = accepts;
      push(8'h7A, 1'b1, ok);
      chk("restart_accept", ok, 1'b1);
      wait_done(3);
      img = '{8'h7A};
      check_writes(w0, acc0, img);
      chk("restart_wc1", bus.word_count, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
